spi_master_mc: RTL
==================

Name: spi_master_mc

Overview:
Parametrised second-generation SPI master. Generates its own SCLK from the system clock through a programmable divider, supports all four CPOL/CPHA modes per transaction, a configurable word width, and NUM_CS independent active-low chip selects. It keeps the existing transmit / receive / full-duplex command set and programmable CS-to-SCLK guard time, and adds a one-cycle start/ready handshake plus an error pulse.

Parameters:
DATA_W, 16, bits per transaction (2..64)
NUM_CS, 4, number of chip-select outputs (1..16)
CS_W, max(1,$clog2(NUM_CS)), width of cs_sel (localparam)
CNT_W, $clog2(DATA_W+1), bit-counter width (localparam)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  request strobe; accepted only when ready=1
cmd  in  2  01 tx, 10 rx, 11 full duplex, 00 no-op
cs_sel  in  CS_W  target slave index
cpol  in  1  SCLK idle level for this transaction
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
clk_div  in  8  SCLK half-period = clk_div+1 clk cycles
wait_duration  in  8  guard time = wait_duration+1 clk cycles before and after the SCLK burst
din  in  DATA_W  transmit word
miso  in  1  serial input
ready  out  1  high in IDLE
busy  out  1  ~ready
dout  out  DATA_W  last received word; holds until the next rx or full-duplex completion
done_tx  out  1  one-cycle pulse at completion of a tx or full-duplex transaction
done_rx  out  1  one-cycle pulse at completion of an rx or full-duplex transaction; dout valid in the same cycle
err  out  1  one-cycle pulse when a request is rejected
sclk  out  1  serial clock
mosi  out  1  serial output
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset: all state is cleared on the clk edge where rst=1. State=IDLE; ready=1, busy=0; sclk=0; mosi=0; cs_n=all 1; dout=0; done_tx=0, done_rx=0, err=0; stored cpol=0.
- FSM states: IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE.
- IDLE: on start=1 with cmd!=00 and cs_sel<NUM_CS, register din, cmd, cs_sel, cpol, cpha, clk_div and wait_duration, then go to LEAD.
  - start with cmd=00: ignored, no err.
  - start with cs_sel>=NUM_CS: err pulses the next cycle; state stays IDLE.
- start while busy: ignored; the registered values are not disturbed.
- sclk sits at the registered cpol from LEAD onward. In IDLE it holds the last registered cpol (0 after reset).
- cs_n[sel]=0 throughout LEAD, XFER and TRAIL; every other cs_n bit stays 1.
- LEAD: wait_duration+1 cycles.
  - cpha=0: mosi is driven with the first bit on entry to LEAD.
- XFER: DATA_W SCLK periods. Each half-period is clk_div+1 cycles, so XFER is 2*DATA_W*(clk_div+1) cycles. Every edge toggles sclk.
  - cpha=0: sample miso on leading edges; shift mosi on trailing edges, except the final trailing edge.
  - cpha=1: shift mosi on leading edges; sample miso on trailing edges.
  - Bits go out MSB first. Received bits shift into a shadow register.
- TRAIL: sclk=cpol, then wait_duration+1 cycles. mosi returns to 0 on entry.
- DONE: one cycle; cs_n all 1.
  - done_tx pulses if cmd[0]; done_rx pulses if cmd[1].
  - dout is loaded from the shadow register in that same cycle.
  - ready rises the following cycle.
- Mode rules:
  - tx-only: miso is ignored and dout is unchanged.
  - rx-only: mosi is held at 0 throughout.
- Latency: the DONE cycle is exactly 2*(wait_duration+1)+2*DATA_W*(clk_div+1)+1 clk edges after the edge that sampled start.
- Boundaries:
  - clk_div=0 gives SCLK=clk/2.
  - wait_duration=255 gives 256-cycle guards.
  - Back-to-back: start high in the first ready cycle is accepted.
- Reset mid-operation: the transaction aborts, cs_n deasserts on the next edge, and no done pulse is produced.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN
- Defined: adds an input port lsb_first (1 bit), registered with start. When it is 1, the tx and rx bit orders are both LSB first, and dout is assembled so the first received bit lands in bit 0.
- Undefined: no port; MSB first always.

Test Plan:
1. Reset during XFER of a tx command -> next cycle cs_n=4'b1111, sclk=0, mosi=0, ready=1; no done pulse.
2. DATA_W=16, mode 0 (cpol=0, cpha=0), cmd=11, din=16'hA5C3, clk_div=1, wait_duration=2, cs_sel=2, miso looped to mosi:
   - cs_n=4'b1011 during the transaction.
   - 16 sclk pulses of 4 cycles each.
   - done_tx and done_rx pulse 71 cycles after start; dout=16'hA5C3.
3. Modes 1, 2 and 3 with a slave model returning 16'h3C5A, cmd=10 -> dout=16'h3C5A in every mode; mosi stays 0; sclk idles at cpol; done_tx never pulses.
4. cs_sel=5 with NUM_CS=4 -> err pulses once, ready stays 1, cs_n stays 4'b1111. start with cmd=00 -> no activity and no err.
5. start held high across a complete cmd=01 transaction -> exactly one transaction runs. A second start in the first ready cycle is accepted. dout is unchanged by the tx-only transaction.
6. SPI_MASTER_LSB_FIRST_EN defined, lsb_first=1, din=16'h0001, loopback -> mosi is 1 on the first bit; dout=16'h0001.

Source files
------------

// File: rtl/spi_master_mc_if.sv
// rtl/spi_master_mc_if.sv - request/status bus of spi_master_mc (lsb_first present with SPI_MASTER_LSB_FIRST_EN)
interface spi_master_mc_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CS = 4
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic [1:0]        cmd;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic [7:0]        clk_div;
  logic [7:0]        wait_duration;
  logic [DATA_W-1:0] din;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic              ready;
  logic              busy;
  logic [DATA_W-1:0] dout;
  logic              done_tx;
  logic              done_rx;
  logic              err;

  modport master (
`ifdef SPI_MASTER_LSB_FIRST_EN
    output lsb_first,
`endif
    output start, cmd, cs_sel, cpol, cpha, clk_div, wait_duration, din,
    input  ready, busy, dout, done_tx, done_rx, err
  );

  modport slave (
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  start, cmd, cs_sel, cpol, cpha, clk_div, wait_duration, din,
    output ready, busy, dout, done_tx, done_rx, err
  );
endinterface

// File: rtl/spi_master_mc.sv
// rtl/spi_master_mc.sv - multi-CS, 4-mode SPI master; SPI_MASTER_LSB_FIRST_EN adds per-transaction lsb_first
module spi_master_mc #(
  parameter int DATA_W = 16,
  parameter int NUM_CS = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_mc_if.slave    bus,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

  state_t            state;
  logic [1:0]        r_cmd;
  logic              r_cpol;
  logic              r_cpha;
  logic [7:0]        r_div;
  logic [7:0]        r_wait;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [7:0]        div_cnt;
  logic [8:0]        gcnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              phase;
  logic [CS_W-1:0]   sel_in;
  logic              lsb_in;
  logic              r_lsb;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = bus.lsb_first;
`else
  assign lsb_in = 1'b0;
  assign r_lsb  = 1'b0;
`endif

  assign sel_in   = bus.cs_sel;
  assign bus.busy = ~bus.ready;

  // Bit order steering: first bit to send on accept, next bit to send, and receive shift.
  logic              first_bit;
  logic [DATA_W-1:0] din_rest;
  logic              tx_bit;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_next;
  logic              last_bit;

  assign first_bit = lsb_in ? bus.din[0] : bus.din[DATA_W-1];
  assign din_rest  = lsb_in ? (bus.din >> 1) : (bus.din << 1);
  assign tx_bit    = r_lsb ? tx_sh[0] : tx_sh[DATA_W-1];
  assign tx_next   = r_lsb ? (tx_sh >> 1) : (tx_sh << 1);
  assign rx_next   = r_lsb ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
  assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));

  // Transaction sequencer: guard, SCLK burst, guard, completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.ready   <= 1'b1;
      bus.dout    <= '0;
      bus.done_tx <= 1'b0;
      bus.done_rx <= 1'b0;
      bus.err     <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      cs_n        <= '1;
      r_cmd       <= 2'b00;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_div       <= 8'd0;
      r_wait      <= 8'd0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      div_cnt     <= 8'd0;
      gcnt        <= 9'd0;
      bit_cnt     <= '0;
      phase       <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
      r_lsb       <= 1'b0;
`endif
    end else begin
      bus.done_tx <= 1'b0;
      bus.done_rx <= 1'b0;
      bus.err     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.cmd != 2'b00) begin
            if (32'(sel_in) < NUM_CS) begin
              state     <= LEAD;
              bus.ready <= 1'b0;
              r_cmd     <= bus.cmd;
              r_cpol    <= bus.cpol;
              r_cpha    <= bus.cpha;
              r_div     <= bus.clk_div;
              r_wait    <= bus.wait_duration;
`ifdef SPI_MASTER_LSB_FIRST_EN
              r_lsb     <= bus.lsb_first;
`endif
              sclk      <= bus.cpol;
              cs_n      <= ~(NUM_CS'(1) << sel_in);
              gcnt      <= 9'd0;
              div_cnt   <= 8'd0;
              bit_cnt   <= '0;
              phase     <= 1'b0;
              rx_sh     <= '0;
              // Mode-0/2 slaves sample on the first edge, so the MSB (or LSB) must already be out.
              if (bus.cmd[0] && !bus.cpha) begin
                mosi  <= first_bit;
                tx_sh <= din_rest;
              end else begin
                mosi  <= 1'b0;
                tx_sh <= bus.din;
              end
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        LEAD: begin
          if (gcnt == {1'b0, r_wait}) state <= XFER;
          else gcnt <= gcnt + 9'd1;
        end
        XFER: begin
          if (div_cnt == r_div) begin
            div_cnt <= 8'd0;
            sclk    <= ~sclk;
            phase   <= ~phase;
            if (!phase) begin
              if (r_cpha) begin
                if (r_cmd[0]) mosi <= tx_bit;
                tx_sh <= tx_next;
              end else begin
                rx_sh <= rx_next;
              end
            end else begin
              if (r_cpha) begin
                rx_sh <= rx_next;
              end else if (!last_bit) begin
                if (r_cmd[0]) mosi <= tx_bit;
                tx_sh <= tx_next;
              end
              if (last_bit) begin
                state <= TRAIL;
                gcnt  <= 9'd0;
                mosi  <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        TRAIL: begin
          // One settling cycle at idle SCLK level, then the trailing guard.
          sclk <= r_cpol;
          if (gcnt == {1'b0, r_wait} + 9'd1) begin
            state       <= DONE;
            cs_n        <= '1;
            bus.done_tx <= r_cmd[0];
            bus.done_rx <= r_cmd[1];
            if (r_cmd[1]) bus.dout <= rx_sh;
          end else begin
            gcnt <= gcnt + 9'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          cs_n      <= '1;
        end
      endcase
    end
  end
endmodule
